// File: rtl/traffic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Purpose  : Shared types and constants for the intersection controllers:
//             pedestrian walk-service state encoding and phase defaults,
//             plus the vehicle controller's state encoding and timings.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package traffic_pkg;

    // Every phase counter in the intersection is a 4-bit tick count.
    localparam int c_CNT_W = 4;
    typedef logic [c_CNT_W-1:0] tick_cnt_t;

    // Pedestrian walk-service phase defaults, in Tick_1Hz pulses.
    localparam tick_cnt_t c_WALK_TICKS  = 4'd7;
    localparam tick_cnt_t c_FLASH_TICKS = 4'd5;
    localparam tick_cnt_t c_GAP_TICKS   = 4'd10;

    typedef enum logic [2:0] {
        PED_IDLE  = 3'd0,
        PED_REQ   = 3'd1,
        PED_WALK  = 3'd2,
        PED_FLASH = 3'd3,
        PED_GAP   = 3'd4
    } ped_state_t;

    // Vehicle controller encoding and timings (shares tick_down_counter).
    typedef enum logic [2:0] {
        VEH_GREEN   = 3'd0,
        VEH_YELLOW  = 3'd1,
        VEH_ALL_RED = 3'd2,
        VEH_PED_HLD = 3'd3
    } veh_state_t;

    localparam tick_cnt_t c_VEH_MIN_GREEN_TICKS = 4'd12;
    localparam tick_cnt_t c_VEH_YELLOW_TICKS    = 4'd3;
    localparam tick_cnt_t c_VEH_ALL_RED_TICKS   = 4'd2;

    // Countdown is only published to the pedestrian display in WALK/FLASH.
    function automatic logic ped_shows_countdown(input ped_state_t s);
        return (s == PED_WALK) || (s == PED_FLASH);
    endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/walk_service_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : walk_service_if
//  Purpose  : Signal bundle between the pedestrian walk-service block and its
//             environment (request latch, tick source, vehicle controller,
//             lamp drivers).
//  Ports    : master - environment side (drives WR, Tick_1Hz, Vehicle_Clear)
//             slave  - walk_service side (drives WR_Reset, Ped_Busy, lamps,
//                      Countdown)
//  Revision : 1.0  initial release
// ============================================================================
interface walk_service_if;
    import traffic_pkg::*;

    logic      WR;
    logic      Tick_1Hz;
    logic      Vehicle_Clear;
    logic      WR_Reset;
    logic      Ped_Busy;
    logic      Walk_Lamp;
    logic      DontWalk_Lamp;
    tick_cnt_t Countdown;

    modport master (
        output WR, Tick_1Hz, Vehicle_Clear,
        input  WR_Reset, Ped_Busy, Walk_Lamp, DontWalk_Lamp, Countdown
    );

    modport slave (
        input  WR, Tick_1Hz, Vehicle_Clear,
        output WR_Reset, Ped_Busy, Walk_Lamp, DontWalk_Lamp, Countdown
    );

endinterface : walk_service_if
`default_nettype wire

// File: rtl/tick_down_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tick_down_counter
//  Purpose  : Phase timer shared by the pedestrian and vehicle controllers.
//             Loads a value, decrements once per tick enable, saturates at 0.
//  Ports    : Clk, Reset_n      - clock, async active-low reset
//             i_load            - load i_load_value (wins over a tick)
//             i_load_value      - value to load
//             i_tick            - decrement enable
//             o_count           - current count
//             o_count_next      - value the count takes at the next edge
//             o_zero            - count is 0
//  Revision : 1.0  initial release
// ============================================================================
module tick_down_counter
    import traffic_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset_n,
    input  logic      i_load,
    input  tick_cnt_t i_load_value,
    input  logic      i_tick,
    output tick_cnt_t o_count,
    output tick_cnt_t o_count_next,
    output logic      o_zero
);

    tick_cnt_t r_count;
    tick_cnt_t w_count_next;

    // Load has priority so that a tick landing on the load edge is not
    // counted; the decrement is blocked at 0 so the count never wraps.
    always_comb begin
        w_count_next = r_count;
        if (i_load) begin
            w_count_next = i_load_value;
        end else if (i_tick && (r_count != '0)) begin
            w_count_next = r_count - tick_cnt_t'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_zero       = (r_count == '0);

endmodule : tick_down_counter
`default_nettype wire

// File: rtl/walk_service.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : walk_service
//  Purpose  : Pedestrian walk-service sequencer. Takes a latched walk request,
//             asks the vehicle controller for all-red, then runs the WALK,
//             flashing Don't-Walk and lock-out GAP phases, each timed in
//             Tick_1Hz pulses.
//  Ports    : Clk      - system clock, rising edge
//             Reset_n  - asynchronous active-low reset
//             bus      - walk_service_if.slave (WR, Tick_1Hz, Vehicle_Clear in;
//                        WR_Reset, Ped_Busy, Walk_Lamp, DontWalk_Lamp,
//                        Countdown out; all outputs registered)
//  Revision : 1.0  initial release
// ============================================================================
module walk_service
    import traffic_pkg::*;
#(
    parameter tick_cnt_t WALK_TICKS  = c_WALK_TICKS,   // 1..15
    parameter tick_cnt_t FLASH_TICKS = c_FLASH_TICKS,  // 1..15
    parameter tick_cnt_t GAP_TICKS   = c_GAP_TICKS     // 1..15
) (
    input  logic          Clk,
    input  logic          Reset_n,
    walk_service_if.slave bus
);

    ped_state_t r_state;
    ped_state_t w_state_next;

    logic      r_wr_reset;
    logic      r_ped_busy;
    logic      r_walk_lamp;
    logic      r_dont_walk_lamp;
    tick_cnt_t r_countdown;

    logic      w_load;
    tick_cnt_t w_load_value;
    tick_cnt_t w_count;
    tick_cnt_t w_count_next;
    logic      w_zero;
    logic      w_expire;

    // A timed phase ends on the tick that takes the count from 1 to 0, so the
    // count shown during a phase runs N..1. The zero term only matters if the
    // count were somehow already 0: the phase then ends instead of stalling.
    assign w_expire = w_zero || (bus.Tick_1Hz && (w_count == tick_cnt_t'(1)));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PED_IDLE: begin
                if (bus.WR) w_state_next = PED_REQ;
            end
            PED_REQ: begin
                // A withdrawn request wins over a same-cycle all-red grant.
                if (!bus.WR) begin
                    w_state_next = PED_IDLE;
                end else if (bus.Vehicle_Clear) begin
                    w_state_next = PED_WALK;
                end
            end
            PED_WALK: begin
                if (w_expire) w_state_next = PED_FLASH;
            end
            PED_FLASH: begin
                if (w_expire) w_state_next = PED_GAP;
            end
            PED_GAP: begin
                if (w_expire) w_state_next = PED_IDLE;
            end
            default: w_state_next = PED_IDLE;
        endcase
    end

    // The counter is reloaded on every state change with the duration of the
    // state being entered (0 for the untimed states).
    assign w_load = (w_state_next != r_state);

    always_comb begin
        case (w_state_next)
            PED_WALK:  w_load_value = WALK_TICKS;
            PED_FLASH: w_load_value = FLASH_TICKS;
            PED_GAP:   w_load_value = GAP_TICKS;
            default:   w_load_value = '0;
        endcase
    end

    tick_down_counter u_phase_cnt (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .i_tick       (bus.Tick_1Hz),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_zero       (w_zero)
    );

    // State plus registered Moore outputs, all derived from the state being
    // entered so they change on the same edge as the state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state          <= PED_IDLE;
            r_wr_reset       <= 1'b0;
            r_ped_busy       <= 1'b0;
            r_walk_lamp      <= 1'b0;
            r_dont_walk_lamp <= 1'b1;
            r_countdown      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wr_reset  <= (r_state == PED_REQ) && (w_state_next == PED_WALK);
            r_ped_busy  <= (w_state_next == PED_REQ)  ||
                           (w_state_next == PED_WALK) ||
                           (w_state_next == PED_FLASH);
            r_walk_lamp <= (w_state_next == PED_WALK);
            r_countdown <= ped_shows_countdown(w_state_next) ? w_count_next : '0;

            case (w_state_next)
                PED_WALK: begin
                    r_dont_walk_lamp <= 1'b0;
                end
                PED_FLASH: begin
                    // Steady on at entry, then one toggle per tick.
                    if (r_state != PED_FLASH) begin
                        r_dont_walk_lamp <= 1'b1;
                    end else if (bus.Tick_1Hz) begin
                        r_dont_walk_lamp <= ~r_dont_walk_lamp;
                    end
                end
                default: begin
                    r_dont_walk_lamp <= 1'b1;
                end
            endcase
        end
    end

    assign bus.WR_Reset      = r_wr_reset;
    assign bus.Ped_Busy      = r_ped_busy;
    assign bus.Walk_Lamp     = r_walk_lamp;
    assign bus.DontWalk_Lamp = r_dont_walk_lamp;
    assign bus.Countdown     = r_countdown;

endmodule : walk_service
`default_nettype wire

// File: tb/tb_walk_service.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_walk_service
//  Purpose  : Self-checking bench for walk_service. A service-level model
//             (request / waiting / ticks elapsed since the walk began) predicts
//             every output each cycle; directed sequences pin the model with
//             hand-computed values, then a randomized request/tick/clearance
//             run follows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_walk_service;
    import traffic_pkg::*;

    localparam int c_W     = 7;
    localparam int c_F     = 5;
    localparam int c_G     = 10;
    localparam int c_TOTAL = c_W + c_F + c_G;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_SVC  = 2;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    logic chk_en  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    walk_service_if bus ();

    walk_service #(
        .WALK_TICKS  (4'd7),
        .FLASH_TICKS (4'd5),
        .GAP_TICKS   (4'd10)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Service-level model: where are we in the service, and how many ticks
    // have elapsed since the Walk phase began.
    // ------------------------------------------------------------------
    int   m_mode  = M_IDLE;
    int   m_ticks = 0;
    logic m_entry = 1'b0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_mode  <= M_IDLE;
            m_ticks <= 0;
            m_entry <= 1'b0;
        end else begin
            m_entry <= 1'b0;
            case (m_mode)
                M_IDLE: if (bus.WR) m_mode <= M_REQ;
                M_REQ: begin
                    if (!bus.WR) begin
                        m_mode <= M_IDLE;
                    end else if (bus.Vehicle_Clear) begin
                        m_mode  <= M_SVC;
                        m_ticks <= 0;
                        m_entry <= 1'b1;
                    end
                end
                default: begin
                    if (bus.Tick_1Hz) begin
                        m_ticks <= m_ticks + 1;
                        if (m_ticks + 1 == c_TOTAL) m_mode <= M_IDLE;
                    end
                end
            endcase
        end
    end

    always @(negedge Clk) begin : compare
        int   e_cd;
        logic e_walk, e_dw, e_busy;
        if (chk_en) begin
            e_walk = 1'b0; e_dw = 1'b1; e_busy = 1'b0; e_cd = 0;
            if (m_mode == M_REQ) begin
                e_busy = 1'b1;
            end else if (m_mode == M_SVC) begin
                if (m_ticks < c_W) begin
                    e_walk = 1'b1; e_dw = 1'b0; e_busy = 1'b1; e_cd = c_W - m_ticks;
                end else if (m_ticks < c_W + c_F) begin
                    e_busy = 1'b1; e_cd = c_W + c_F - m_ticks;
                    e_dw   = (((m_ticks - c_W) % 2) == 0);
                end
            end
            chk("walk_lamp", 32'(bus.Walk_Lamp), 32'(e_walk));
            chk("dontwalk_lamp", 32'(bus.DontWalk_Lamp), 32'(e_dw));
            chk("ped_busy", 32'(bus.Ped_Busy), 32'(e_busy));
            chk("wr_reset", 32'(bus.WR_Reset), 32'(m_entry));
            chk("countdown", 32'(bus.Countdown), 32'(e_cd));
            chk("lamps_exclusive", 32'(bus.Walk_Lamp & bus.DontWalk_Lamp), 32'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int        walk_ticks, gap_ticks, flash_idx, nwrr, phase, cyc, guard;
    logic [4:0] flash_seq;
    logic [3:0] cd_exp;
    logic       cd_ok, done, wr_l;

    initial begin
        bus.WR = 1'b0; bus.Tick_1Hz = 1'b0; bus.Vehicle_Clear = 1'b0;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_walk", 32'(bus.Walk_Lamp), 32'd0);
        chk("rst_dontwalk", 32'(bus.DontWalk_Lamp), 32'd1);
        chk("rst_busy", 32'(bus.Ped_Busy), 32'd0);
        chk("rst_wr_reset", 32'(bus.WR_Reset), 32'd0);
        chk("rst_countdown", 32'(bus.Countdown), 32'd0);
        Reset_n = 1'b1;
        chk_en  = 1'b1;

        // Full service with clearance granted, tick on the WALK entry edge
        bus.WR = 1'b1; bus.Vehicle_Clear = 1'b1;
        @(negedge Clk);
        chk("req_busy", 32'(bus.Ped_Busy), 32'd1);
        chk("req_walk", 32'(bus.Walk_Lamp), 32'd0);
        bus.Tick_1Hz = 1'b1;
        @(negedge Clk);
        chk("entry_walk", 32'(bus.Walk_Lamp), 32'd1);
        chk("entry_wr_reset", 32'(bus.WR_Reset), 32'd1);
        chk("entry_countdown", 32'(bus.Countdown), 32'd7);
        bus.Tick_1Hz = 1'b0; bus.WR = 1'b0;

        walk_ticks = 0; gap_ticks = 0; flash_idx = 0; nwrr = 0; phase = 1;
        flash_seq = '0; cd_exp = 4'd7; cd_ok = 1'b1; done = 1'b0; cyc = 1;
        while (!done && cyc < 400) begin
            if (bus.WR_Reset) nwrr++;
            if (phase == 1 && !bus.Walk_Lamp) phase = 2;
            if (phase == 2 && !bus.Ped_Busy)  phase = 3;
            if (phase == 3 && bus.Ped_Busy) begin
                done = 1'b1;
            end else begin
                if (phase == 1 && bus.Countdown == 4'd4) bus.WR = 1'b1;
                bus.Tick_1Hz = ((cyc % 3) == 0);
                if (bus.Tick_1Hz) begin
                    case (phase)
                        1: begin
                            walk_ticks++;
                            if (bus.Countdown != cd_exp) cd_ok = 1'b0;
                            cd_exp = cd_exp - 4'd1;
                        end
                        2: begin
                            if (flash_idx < 5) flash_seq[4 - flash_idx] = bus.DontWalk_Lamp;
                            flash_idx++;
                        end
                        default: gap_ticks++;
                    endcase
                end
                if (phase == 3) bus.Vehicle_Clear = 1'b0;
                @(negedge Clk);
                cyc++;
            end
        end
        chk("svc_completed", 32'(done), 32'd1);
        chk("walk_tick_count", 32'(walk_ticks), 32'd7);
        chk("walk_countdown_7_to_1", 32'(cd_ok), 32'd1);
        chk("flash_tick_count", 32'(flash_idx), 32'd5);
        chk("flash_pattern", 32'(flash_seq), 32'b10101);
        chk("gap_tick_count", 32'(gap_ticks), 32'd10);
        chk("wr_reset_pulses", 32'(nwrr), 32'd1);

        // Waiting in REQ without clearance
        bus.Tick_1Hz = 1'b0; bus.Vehicle_Clear = 1'b0;
        repeat (20) @(negedge Clk);
        chk("wait_busy", 32'(bus.Ped_Busy), 32'd1);
        chk("wait_walk", 32'(bus.Walk_Lamp), 32'd0);
        bus.Vehicle_Clear = 1'b1;
        @(negedge Clk);
        chk("clear_walk", 32'(bus.Walk_Lamp), 32'd1);
        chk("clear_wr_reset", 32'(bus.WR_Reset), 32'd1);
        bus.WR = 1'b0; bus.Vehicle_Clear = 1'b0;

        // Asynchronous reset mid-WALK at Countdown 4, request still latched
        guard = 0;
        while (bus.Countdown != 4'd4 && guard < 100) begin
            bus.Tick_1Hz = ((guard % 2) == 0);
            @(negedge Clk);
            guard++;
        end
        chk("reach_countdown_4", 32'(bus.Countdown), 32'd4);
        bus.Tick_1Hz = 1'b0;
        bus.WR = 1'b1;
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_walk", 32'(bus.Walk_Lamp), 32'd0);
        chk("async_rst_dontwalk", 32'(bus.DontWalk_Lamp), 32'd1);
        chk("async_rst_countdown", 32'(bus.Countdown), 32'd0);
        chk("async_rst_busy", 32'(bus.Ped_Busy), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_req", 32'(bus.Ped_Busy), 32'd1);

        // Withdrawal beats a same-cycle clearance
        bus.WR = 1'b0; bus.Vehicle_Clear = 1'b1;
        @(negedge Clk);
        chk("abort_busy", 32'(bus.Ped_Busy), 32'd0);
        chk("abort_walk", 32'(bus.Walk_Lamp), 32'd0);

        // Randomized run with a request latch cleared by WR_Reset
        wr_l = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.WR_Reset) wr_l = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                wr_l = 1'b1;
            end else if (wr_l && $urandom_range(0, 49) == 0) begin
                wr_l = 1'b0;
            end
            bus.WR            = wr_l;
            bus.Vehicle_Clear = ($urandom_range(0, 3) != 0);
            bus.Tick_1Hz      = ($urandom_range(0, 2) == 0);
            @(negedge Clk);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_walk_service
`default_nettype wire

// File: doc/walk_service.md
WALK_SERVICE -- requirements
Module: walk_service

Interface
REQ-001 Parameter WALK_TICKS, default 7, Walk lamp duration in Tick_1Hz pulses; legal range 1..15.
REQ-002 Parameter FLASH_TICKS, default 5, flashing Don't-Walk duration in ticks; legal range 1..15.
REQ-003 Parameter GAP_TICKS, default 10, minimum ticks between end of one service and acceptance of the next; legal range 1..15.
REQ-004 Clk  input  1  single system clock; all logic on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 WR  input  1  latched pedestrian walk request (level), already synchronous to Clk.
REQ-007 Tick_1Hz  input  1  one-Clk-wide timing enable.
REQ-008 Vehicle_Clear  input  1  vehicle controller reports all conflicting vehicle heads red.
REQ-009 WR_Reset  output  1  one-cycle pulse that clears the walk request latch.
REQ-010 Ped_Busy  output  1  requests that the vehicle controller hold or enter all-red.
REQ-011 Walk_Lamp  output  1  Walk indication.
REQ-012 DontWalk_Lamp  output  1  Don't-Walk indication (steady or flashing).
REQ-013 Countdown  output  4  remaining ticks in the current WALK/FLASH phase, else 0.

Function
REQ-014 The block SHALL be a Moore FSM with states IDLE, REQ, WALK, FLASH, GAP, with all outputs registered.
REQ-015 IDLE: DontWalk_Lamp=1, others 0; WR=1 -> REQ on the next edge.
REQ-016 REQ: Ped_Busy=1, DontWalk_Lamp=1; Vehicle_Clear=1 -> WALK; WR=0 -> IDLE (abort); WR=0 takes priority over Vehicle_Clear=1 in the same cycle.
REQ-017 On the cycle of entry into WALK, the block SHALL assert WR_Reset for exactly one Clk, so requests arriving during WALK/FLASH/GAP re-latch and are served later.
REQ-018 WALK: Walk_Lamp=1, DontWalk_Lamp=0, Ped_Busy=1; counter loaded with WALK_TICKS on entry and decremented on each Tick_1Hz; at 0 -> FLASH.
REQ-019 A Tick_1Hz coincident with the state-entry edge SHALL NOT be counted; counting starts with the first tick after entry.
REQ-020 FLASH: Walk_Lamp=0, Ped_Busy=1; DontWalk_Lamp=1 on entry and toggles on each Tick_1Hz; counter loaded with FLASH_TICKS; at 0 -> GAP.
REQ-021 GAP: DontWalk_Lamp=1 steady, Ped_Busy=0; counter loaded with GAP_TICKS; at 0 -> IDLE; WR is ignored while in GAP.
REQ-022 Countdown SHALL equal the counter value in WALK and FLASH, and 0 in all other states.
REQ-023 Once in WALK or FLASH, deassertion of Vehicle_Clear SHALL NOT shorten or abort the phase.
REQ-024 The counter SHALL be 4 bits, SHALL never underflow, and SHALL hold at 0 until the state change.
REQ-025 Walk_Lamp and DontWalk_Lamp SHALL never both be 1 in the same cycle.

Reset
REQ-026 Reset_n=0 SHALL asynchronously force state IDLE, counter 0, WR_Reset=0, Ped_Busy=0, Walk_Lamp=0, DontWalk_Lamp=1 and Countdown=0, including when asserted mid-WALK.
REQ-027 After Reset_n deasserts, a still-asserted WR SHALL be served normally via IDLE -> REQ.

Structure
REQ-028 State encodings and parameter default values SHALL live in a shared package, traffic_pkg, together with the vehicle controller's constants.
REQ-029 The phase counter (load, tick-decrement, zero flag) SHALL be a single sub-module, tick_down_counter, reusable by the vehicle controller.

Verification
REQ-030 WR=1 with Vehicle_Clear=1: IDLE -> REQ -> WALK; one WR_Reset pulse; Walk_Lamp high for exactly 7 ticks; Countdown reads 7..1.
REQ-031 Full service, default parameters: FLASH phase shows 5 ticks with DontWalk_Lamp toggling 1,0,1,0,1; GAP lasts 10 ticks; return to IDLE.
REQ-032 WR=1 with Vehicle_Clear held 0 for 20 cycles: stays in REQ with Ped_Busy=1; Vehicle_Clear=1 -> WALK on the next edge.
REQ-033 WR re-asserted mid-WALK: no effect until GAP ends, then REQ entered with no WR pulse missed.
REQ-034 Reset_n pulsed low mid-WALK at Countdown=4: Walk_Lamp=0 and DontWalk_Lamp=1 immediately, without waiting for a Clk edge.
REQ-035 Tick_1Hz coincident with the WALK entry edge: Walk phase still spans 7 subsequent ticks.
